pic_priority_core: RTL and testbench
====================================

// Module: pic_priority_core
// PURPOSE
//  Clocked, parametrised interrupt core for the 8259-style PIC: IRR/ISR/IMR registers, a priority resolver, and the two-pulse INTA sequencer.
//  Generalises the fixed 8-input control unit:
//   - NUM_IRQ channels
//   - edge or level triggering
//   - fully-nested or automatic-rotation priority
//   - AEOI, non-specific EOI and specific EOI
//   - spurious-interrupt vector
//  Sits between the IR pins and the Control_Unit/read-write logic. Configuration comes from decoded ICW/OCW strobes.
// PARAMETERS
//  NUM_IRQ  8  number of request lines; allowed values 2, 4, 8, 16
//  ID_W     $clog2(NUM_IRQ)  channel-index width (derived, do not override)
// PORTS
//  CLK          in   1        system clock, rising-edge active
//  RESET        in   1        asynchronous, active-high reset
//  IR           in   NUM_IRQ  interrupt request lines, synchronous to CLK
//  LTIM         in   1        1 = level-triggered, 0 = edge-triggered
//  AEOI_EN      in   1        1 = automatic EOI at end of the 2nd INTA pulse
//  ROTATE_EN    in   1        1 = rotate priority on EOI or AEOI
//  IMR_WR       in   1        1-cycle strobe: IMR <= IMR_DATA
//  IMR_DATA     in   NUM_IRQ  mask data, 1 = masked
//  EOI_CMD      in   1        1-cycle strobe: non-specific EOI
//  SEOI_CMD     in   1        1-cycle strobe: specific EOI on SEOI_LEVEL
//  SEOI_LEVEL   in   ID_W     channel cleared by SEOI_CMD
//  VECTOR_BASE  in   8        ICW2 value; bits [ID_W-1:0] are ignored
//  INTA_        in   1        active-low acknowledge, sampled on CLK
//  INT          out  1        registered interrupt request to the CPU
//  DATA_OUT     out  8        vector = {VECTOR_BASE[7:ID_W], id}
//  DATA_OE      out  1        1 = DATA_OUT is valid on the bus
//  INTA_COUNT   out  2        INTA falling edges seen in the current sequence (0..2)
//  IRR, ISR, IMR out NUM_IRQ  register contents, for read-back
// BEHAVIOUR
//  Reset values (async): IRR=0, ISR=0, IMR=0, INT=0, DATA_OUT=0, DATA_OE=0, INTA_COUNT=0, state IDLE, IR_q=0, INTA_q=1, LOWP=NUM_IRQ-1.
//  IRR update:
//   - Edge mode: IRR[i] sets the cycle after IR[i] is sampled 1 while IR_q[i]=0. It clears only at ACK1 for the acknowledged id.
//   - Level mode: IRR[i] <= IR[i] every cycle.
//  Priority:
//   - The highest-priority channel is (LOWP+1) mod NUM_IRQ; priority descends cyclically from it.
//   - The winner is the highest-priority bit of IRR & ~IMR.
//   - INT <= 1 (registered) when a winner exists, it outranks every ISR bit, and state is IDLE.
//   - Latency: the IR edge is sampled at clock k, IRR is set after k, and INT is high after k+1.
//  INTA edge detection: INTA_ is registered into INTA_q. A fall is INTA_q=1 with INTA_=0; a rise is INTA_q=0 with INTA_=1.
//  FSM (IDLE -> ACK1 -> ACK2 -> IDLE):
//   - IDLE, on fall: latch id = winner. If a winner exists, set ISR[id] and clear IRR[id] in edge mode. Then INT<=0, INTA_COUNT<=1, go to ACK1.
//   - IDLE, fall with no winner: spurious. id=NUM_IRQ-1 and ISR is unchanged.
//   - ACK1, on fall: INTA_COUNT<=2, DATA_OUT<=vector(id), DATA_OE<=1, go to ACK2.
//   - ACK2: DATA_OE stays 1 while INTA_ is low.
//   - ACK2, on rise: DATA_OE<=0 and INTA_COUNT<=0. If AEOI_EN and not spurious: clear ISR[id], and set LOWP<=id if ROTATE_EN. Go to IDLE.
//   - A fall while in ACK2 is ignored.
//  Latched id is frozen from ACK1 onwards. IMR writes or IR changes mid-sequence do not alter the id or the vector.
//  EOI_CMD: clear the highest-priority set ISR bit (using the current LOWP). If ROTATE_EN, LOWP<=that id. If ISR=0, no effect.
//  SEOI_CMD: clear ISR[SEOI_LEVEL]; LOWP is unchanged. If EOI_CMD and SEOI_CMD arrive together, SEOI_CMD wins.
//  Same-cycle ack and EOI:
//   - EOI is resolved against ISR before the ack.
//   - If both target the same bit, the set wins.
//   - IMR_WR takes effect for the next cycle's resolution.
//  RESET mid-sequence: everything returns to reset values immediately. DATA_OE drops asynchronously.
// TESTING
//  - Reset, edge mode: pulse IR[2] for 1 cycle -> INT=1 two clocks after the edge is sampled. Two INTA_ pulses (base 8'hF8) -> ISR=8'h04, IRR=0, DATA_OUT=8'hFA with DATA_OE=1 during the 2nd pulse, INTA_COUNT 1 then 2 then 0. EOI_CMD -> ISR=0.
//  - Nesting: IR[5] acknowledged (ISR=8'h20), then IR[6] rises -> INT stays 0. IR[1] rises -> INT=1; after its acks, ISR=8'h22 and the vector is base|1.
//  - IMR=8'h04 with IR[2]=1 -> INT=0. Write IMR=0 -> INT=1 two cycles later. AEOI_EN=1, then acknowledge -> ISR=0 after the 2nd INTA rise.
//  - Rotation: ROTATE_EN=1, IR[0] and IR[3] pending. Acknowledge IR[0] then EOI -> LOWP=0 and IR[3] wins next. Re-raise IR[0] with IR[1] pending -> IR[1] outranks IR[0].
//  - Spurious: INTA_ pulses with IRR=0 -> vector=base|(NUM_IRQ-1) and ISR unchanged. Level mode: drop IR before the 1st INTA -> spurious.
//  - Assert RESET during ACK2 -> DATA_OE=0 at once, all registers zero, and a new IR edge works normally. Repeat the first scenario with NUM_IRQ=16 -> vector {base[7:4], 4'hA} for IR[10].

Source files
------------

// File: rtl/pic_priority_core.sv
// pic_priority_core: IRR/ISR/IMR registers, cyclic priority resolver and
// the two-pulse INTA sequencer of an 8259-style interrupt controller.
//
// Acknowledge protocol: the CPU answers a registered INT with two falling
// edges on INTA_. The first fall freezes the winning channel into id_q and
// moves it from IRR to ISR. The second fall drives the vector onto DATA_OUT
// with DATA_OE=1, and DATA_OE stays high until INTA_ rises again. Edges are
// detected against the registered copy inta_q, one event per CLK.
module pic_priority_core #(
  parameter int NUM_IRQ = 8,
  parameter int ID_W    = $clog2(NUM_IRQ)
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic [NUM_IRQ-1:0] IR,
  input  logic               LTIM,
  input  logic               AEOI_EN,
  input  logic               ROTATE_EN,
  input  logic               IMR_WR,
  input  logic [NUM_IRQ-1:0] IMR_DATA,
  input  logic               EOI_CMD,
  input  logic               SEOI_CMD,
  input  logic [ID_W-1:0]    SEOI_LEVEL,
  input  logic [7:0]         VECTOR_BASE,
  input  logic               INTA_,
  output logic               INT,
  output logic [7:0]         DATA_OUT,
  output logic               DATA_OE,
  output logic [1:0]         INTA_COUNT,
  output logic [NUM_IRQ-1:0] IRR,
  output logic [NUM_IRQ-1:0] ISR,
  output logic [NUM_IRQ-1:0] IMR,
  output logic [1:0]         DBG_STATE
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACK1 = 2'd1,
    ACK2 = 2'd2
  } state_t;

  // Low ID_W bits of the vector come from the channel index, not the base.
  localparam logic [7:0] ID_MASK = 8'((1 << ID_W) - 1);
  localparam logic [ID_W-1:0] SPUR_ID = ID_W'(NUM_IRQ - 1);

  state_t             state_q, state_d;
  logic [NUM_IRQ-1:0] irr_q, irr_d;
  logic [NUM_IRQ-1:0] isr_q, isr_d;
  logic [NUM_IRQ-1:0] imr_q, imr_d;
  logic [NUM_IRQ-1:0] ir_q, ir_d;
  logic               inta_q, inta_d;
  logic               int_q, int_d;
  logic [7:0]         data_out_q, data_out_d;
  logic               data_oe_q, data_oe_d;
  logic [1:0]         inta_count_q, inta_count_d;
  logic [ID_W-1:0]    lowp_q, lowp_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic               spurious_q, spurious_d;

  // Highest-priority set bit of req; priority starts at lowp+1 and descends
  // cyclically. Result is {found, index}. The loop walks from lowest to
  // highest priority so the last hit is the winner.
  function automatic logic [ID_W:0] pick(input logic [NUM_IRQ-1:0] req,
                                         input logic [ID_W-1:0]    lowp);
    logic [ID_W:0]   res;
    logic [ID_W-1:0] idx;
    res = '0;
    for (int k = NUM_IRQ - 1; k >= 0; k--) begin
      idx = lowp + ID_W'(k + 1);
      if (req[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  // Priority rank of a channel: 0 is highest, NUM_IRQ-1 is lowest.
  function automatic logic [ID_W-1:0] rank(input logic [ID_W-1:0] id,
                                           input logic [ID_W-1:0] lowp);
    return id + ~lowp;
  endfunction

  logic               fall, rise;
  logic [NUM_IRQ-1:0] edges;
  logic [ID_W:0]      win, top;
  logic               win_v, top_v, outranks;
  logic [ID_W-1:0]    win_id, top_id;
  logic [7:0]         vector;

  // Edge detection, priority resolution and vector formation.
  always_comb begin
    fall     = inta_q & ~INTA_;
    rise     = ~inta_q & INTA_;
    edges    = IR & ~ir_q;
    win      = pick(irr_q & ~imr_q, lowp_q);
    top      = pick(isr_q, lowp_q);
    win_v    = win[ID_W];
    win_id   = win[ID_W-1:0];
    top_v    = top[ID_W];
    top_id   = top[ID_W-1:0];
    outranks = win_v && (!top_v || (rank(win_id, lowp_q) < rank(top_id, lowp_q)));
    vector   = (VECTOR_BASE & ~ID_MASK) | 8'(id_q);
  end

  // Next-state logic: EOI commands first, then the INTA sequencer, so a
  // same-cycle acknowledge set on the same ISR bit overrides the clear.
  always_comb begin
    state_d      = state_q;
    irr_d        = LTIM ? IR : irr_q;
    isr_d        = isr_q;
    imr_d        = IMR_WR ? IMR_DATA : imr_q;
    ir_d         = IR;
    inta_d       = INTA_;
    int_d        = 1'b0;
    data_out_d   = data_out_q;
    data_oe_d    = data_oe_q;
    inta_count_d = inta_count_q;
    lowp_d       = lowp_q;
    id_d         = id_q;
    spurious_d   = spurious_q;

    if (SEOI_CMD) begin
      isr_d[SEOI_LEVEL] = 1'b0;
    end else if (EOI_CMD && top_v) begin
      isr_d[top_id] = 1'b0;
      if (ROTATE_EN) lowp_d = top_id;
    end

    case (state_q)
      IDLE: begin
        if (fall) begin
          if (win_v) begin
            id_d          = win_id;
            spurious_d    = 1'b0;
            isr_d[win_id] = 1'b1;
            if (!LTIM) irr_d[win_id] = 1'b0;
          end else begin
            id_d       = SPUR_ID;
            spurious_d = 1'b1;
          end
          inta_count_d = 2'd1;
          state_d      = ACK1;
        end else begin
          int_d = outranks;
        end
      end
      ACK1: begin
        if (fall) begin
          inta_count_d = 2'd2;
          data_out_d   = vector;
          data_oe_d    = 1'b1;
          state_d      = ACK2;
        end
      end
      ACK2: begin
        if (rise) begin
          data_oe_d    = 1'b0;
          inta_count_d = 2'd0;
          if (AEOI_EN && !spurious_q) begin
            isr_d[id_q] = 1'b0;
            if (ROTATE_EN) lowp_d = id_q;
          end
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // New edges are recorded after the acknowledge clear, so an edge arriving
    // in the acknowledge cycle is not lost.
    if (!LTIM) irr_d = irr_d | edges;
  end

  // State and register update with asynchronous reset.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q      <= IDLE;
      irr_q        <= '0;
      isr_q        <= '0;
      imr_q        <= '0;
      ir_q         <= '0;
      inta_q       <= 1'b1;
      int_q        <= 1'b0;
      data_out_q   <= 8'h00;
      data_oe_q    <= 1'b0;
      inta_count_q <= 2'd0;
      lowp_q       <= SPUR_ID;
      id_q         <= '0;
      spurious_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      irr_q        <= irr_d;
      isr_q        <= isr_d;
      imr_q        <= imr_d;
      ir_q         <= ir_d;
      inta_q       <= inta_d;
      int_q        <= int_d;
      data_out_q   <= data_out_d;
      data_oe_q    <= data_oe_d;
      inta_count_q <= inta_count_d;
      lowp_q       <= lowp_d;
      id_q         <= id_d;
      spurious_q   <= spurious_d;
    end
  end

  assign INT        = int_q;
  assign DATA_OUT   = data_out_q;
  assign DATA_OE    = data_oe_q;
  assign INTA_COUNT = inta_count_q;
  assign IRR        = irr_q;
  assign ISR        = isr_q;
  assign IMR        = imr_q;
  assign DBG_STATE  = state_q;

endmodule

// File: tb/tb_pic_priority_core.sv
// Directed bench for pic_priority_core: an 8-channel and a 16-channel
// instance share clock, reset and control; each has its own IR/IMR/level.
module tb_pic_priority_core;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  ir8 = '0;
  logic [15:0] ir16 = '0;
  logic        ltim = 1'b0, aeoi = 1'b0, rot = 1'b0, imr_wr = 1'b0;
  logic [7:0]  imr8 = '0;
  logic [15:0] imr16 = '0;
  logic        eoi = 1'b0, seoi = 1'b0;
  logic [2:0]  lvl8 = '0;
  logic [3:0]  lvl16 = '0;
  logic [7:0]  base = 8'hF8;
  logic        inta_n = 1'b1;

  logic        int8, oe8;
  logic [7:0]  dout8, irr8, isr8, imro8;
  logic [1:0]  cnt8, st8;
  logic        int16, oe16;
  logic [7:0]  dout16;
  logic [15:0] irr16, isr16, imro16;
  logic [1:0]  cnt16, st16;

  int checks = 0;
  int failures = 0;

  pic_priority_core #(.NUM_IRQ(8)) dut8 (
    .CLK(clk), .RESET(rst), .IR(ir8), .LTIM(ltim), .AEOI_EN(aeoi),
    .ROTATE_EN(rot), .IMR_WR(imr_wr), .IMR_DATA(imr8), .EOI_CMD(eoi),
    .SEOI_CMD(seoi), .SEOI_LEVEL(lvl8), .VECTOR_BASE(base), .INTA_(inta_n),
    .INT(int8), .DATA_OUT(dout8), .DATA_OE(oe8), .INTA_COUNT(cnt8),
    .IRR(irr8), .ISR(isr8), .IMR(imro8), .DBG_STATE(st8)
  );

  pic_priority_core #(.NUM_IRQ(16)) dut16 (
    .CLK(clk), .RESET(rst), .IR(ir16), .LTIM(ltim), .AEOI_EN(aeoi),
    .ROTATE_EN(rot), .IMR_WR(imr_wr), .IMR_DATA(imr16), .EOI_CMD(eoi),
    .SEOI_CMD(seoi), .SEOI_LEVEL(lvl16), .VECTOR_BASE(base), .INTA_(inta_n),
    .INT(int16), .DATA_OUT(dout16), .DATA_OE(oe16), .INTA_COUNT(cnt16),
    .IRR(irr16), .ISR(isr16), .IMR(imro16), .DBG_STATE(st16)
  );

  // Clock: 10 time-unit period; inputs change and outputs are sampled on negedge.
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    ir8 = '0; ir16 = '0; ltim = 1'b0; aeoi = 1'b0; rot = 1'b0;
    imr_wr = 1'b0; eoi = 1'b0; seoi = 1'b0; inta_n = 1'b1;
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    step(1);
  endtask

  task automatic inta_low();
    inta_n = 1'b0;
    step(1);
  endtask

  task automatic inta_high();
    inta_n = 1'b1;
    step(1);
  endtask

  task automatic pulse_ir8(input logic [7:0] v);
    ir8 = v;
    step(1);
    ir8 = '0;
  endtask

  task automatic pulse_eoi();
    eoi = 1'b1;
    step(1);
    eoi = 1'b0;
  endtask

  task automatic pulse_seoi(input logic [2:0] lvl);
    lvl8 = lvl;
    seoi = 1'b1;
    step(1);
    seoi = 1'b0;
  endtask

  initial begin
    // Reset state
    step(1);
    do_reset();
    chk("rst_irr",   32'(irr8), 32'h0);
    chk("rst_isr",   32'(isr8), 32'h0);
    chk("rst_imr",   32'(imro8), 32'h0);
    chk("rst_int",   32'(int8), 32'h0);
    chk("rst_dout",  32'(dout8), 32'h0);
    chk("rst_oe",    32'(oe8), 32'h0);
    chk("rst_cnt",   32'(cnt8), 32'h0);
    chk("rst_state", 32'(st8), 32'h0);
    chk("rst_isr16", 32'(isr16), 32'h0);

    // Basic edge-mode acknowledge of IR[2]
    pulse_ir8(8'h04);
    chk("s1_irr_set",  32'(irr8), 32'h04);
    chk("s1_int_lat0", 32'(int8), 32'h0);
    step(1);
    chk("s1_int_lat1", 32'(int8), 32'h1);
    inta_low();
    chk("s1_isr",   32'(isr8), 32'h04);
    chk("s1_irr",   32'(irr8), 32'h0);
    chk("s1_int0",  32'(int8), 32'h0);
    chk("s1_cnt1",  32'(cnt8), 32'h1);
    chk("s1_st1",   32'(st8), 32'h1);
    inta_high();
    chk("s1_cnt1b", 32'(cnt8), 32'h1);
    chk("s1_oe0",   32'(oe8), 32'h0);
    inta_low();
    chk("s1_cnt2",  32'(cnt8), 32'h2);
    chk("s1_oe1",   32'(oe8), 32'h1);
    chk("s1_vec",   32'(dout8), 32'hFA);
    chk("s1_st2",   32'(st8), 32'h2);
    inta_high();
    chk("s1_cnt0",  32'(cnt8), 32'h0);
    chk("s1_oe_off", 32'(oe8), 32'h0);
    chk("s1_st0",   32'(st8), 32'h0);
    pulse_eoi();
    chk("s1_eoi",   32'(isr8), 32'h0);

    // Fully nested: IR[6] blocked by in-service IR[5], IR[1] interrupts it
    do_reset();
    pulse_ir8(8'h20);
    step(1);
    chk("s2_int5", 32'(int8), 32'h1);
    inta_low(); inta_high(); inta_low();
    chk("s2_vec5", 32'(dout8), 32'hFD);
    inta_high();
    chk("s2_isr5", 32'(isr8), 32'h20);
    pulse_ir8(8'h40);
    step(2);
    chk("s2_int6_blocked", 32'(int8), 32'h0);
    chk("s2_irr6", 32'(irr8), 32'h40);
    pulse_ir8(8'h02);
    step(1);
    chk("s2_int1", 32'(int8), 32'h1);
    inta_low(); inta_high(); inta_low();
    chk("s2_vec1", 32'(dout8), 32'hF9);
    inta_high();
    chk("s2_isr51", 32'(isr8), 32'h22);
    chk("s2_irr_left", 32'(irr8), 32'h40);
    pulse_seoi(3'd5);
    chk("s2_seoi5", 32'(isr8), 32'h02);
    // SEOI on an idle level together with EOI: SEOI wins, ISR unchanged
    eoi = 1'b1;
    pulse_seoi(3'd6);
    eoi = 1'b0;
    chk("s2_seoi_wins", 32'(isr8), 32'h02);
    pulse_eoi();
    chk("s2_eoi1", 32'(isr8), 32'h0);

    // Masking, unmask latency and automatic EOI
    do_reset();
    imr8 = 8'h04; imr_wr = 1'b1;
    step(1);
    imr_wr = 1'b0;
    chk("s3_imr", 32'(imro8), 32'h04);
    ir8 = 8'h04;
    step(3);
    chk("s3_irr_masked", 32'(irr8), 32'h04);
    chk("s3_int_masked", 32'(int8), 32'h0);
    imr8 = 8'h00; imr_wr = 1'b1;
    step(1);
    imr_wr = 1'b0;
    chk("s3_int_unmask1", 32'(int8), 32'h0);
    step(1);
    chk("s3_int_unmask2", 32'(int8), 32'h1);
    aeoi = 1'b1;
    inta_low(); inta_high(); inta_low();
    chk("s3_isr_ack", 32'(isr8), 32'h04);
    chk("s3_vec", 32'(dout8), 32'hFA);
    inta_high();
    chk("s3_aeoi", 32'(isr8), 32'h0);
    ir8 = '0; aeoi = 1'b0;

    // Rotation on EOI; specific EOI keeps LOWP
    do_reset();
    rot = 1'b1;
    pulse_ir8(8'h09);
    step(1);
    chk("s4_int", 32'(int8), 32'h1);
    inta_low(); inta_high(); inta_low();
    chk("s4_vec0", 32'(dout8), 32'hF8);
    chk("s4_isr0", 32'(isr8), 32'h01);
    inta_high();
    pulse_eoi();
    chk("s4_eoi", 32'(isr8), 32'h0);
    step(1);
    chk("s4_int3", 32'(int8), 32'h1);
    inta_low(); inta_high(); inta_low();
    chk("s4_vec3", 32'(dout8), 32'hFB);
    inta_high();
    pulse_seoi(3'd3);
    chk("s4_seoi3", 32'(isr8), 32'h0);
    pulse_ir8(8'h03);
    step(1);
    chk("s4_int01", 32'(int8), 32'h1);
    inta_low(); inta_high(); inta_low();
    chk("s4_vec1_outranks0", 32'(dout8), 32'hF9);
    inta_high();
    chk("s4_isr1", 32'(isr8), 32'h02);
    chk("s4_irr0", 32'(irr8), 32'h01);
    rot = 1'b0;

    // Spurious acknowledge, edge then level mode
    do_reset();
    inta_low();
    chk("s5_cnt1", 32'(cnt8), 32'h1);
    chk("s5_isr", 32'(isr8), 32'h0);
    inta_high(); inta_low();
    chk("s5_vec_spur", 32'(dout8), 32'hFF);
    chk("s5_oe", 32'(oe8), 32'h1);
    inta_high();
    chk("s5_isr_after", 32'(isr8), 32'h0);
    chk("s5_cnt0", 32'(cnt8), 32'h0);
    ltim = 1'b1;
    ir8 = 8'h04;
    step(1);
    chk("s5_lvl_irr", 32'(irr8), 32'h04);
    step(1);
    chk("s5_lvl_int", 32'(int8), 32'h1);
    ir8 = '0;
    step(1);
    chk("s5_lvl_irr0", 32'(irr8), 32'h0);
    inta_low();
    chk("s5_lvl_isr", 32'(isr8), 32'h0);
    chk("s5_lvl_int0", 32'(int8), 32'h0);
    inta_high(); inta_low();
    chk("s5_lvl_vec", 32'(dout8), 32'hFF);
    inta_high();
    ltim = 1'b0;

    // Asynchronous reset in ACK2, then normal operation
    do_reset();
    pulse_ir8(8'h04);
    step(1);
    inta_low(); inta_high(); inta_low();
    chk("s6_oe_pre", 32'(oe8), 32'h1);
    rst = 1'b1;
    #1;
    chk("s6_oe_async", 32'(oe8), 32'h0);
    chk("s6_isr", 32'(isr8), 32'h0);
    chk("s6_irr", 32'(irr8), 32'h0);
    chk("s6_cnt", 32'(cnt8), 32'h0);
    chk("s6_st", 32'(st8), 32'h0);
    inta_n = 1'b1;
    step(1);
    rst = 1'b0;
    step(1);
    pulse_ir8(8'h04);
    step(1);
    chk("s6_int_again", 32'(int8), 32'h1);
    inta_low(); inta_high(); inta_low();
    chk("s6_vec_again", 32'(dout8), 32'hFA);
    inta_high();

    // 16-channel instance, IR[10]; low base bits are ignored
    do_reset();
    base = 8'h42;
    ir16 = 16'h0400;
    step(1);
    ir16 = '0;
    chk("s7_irr16", 32'(irr16), 32'h0400);
    step(1);
    chk("s7_int16", 32'(int16), 32'h1);
    inta_low();
    chk("s7_isr16", 32'(isr16), 32'h0400);
    inta_high(); inta_low();
    chk("s7_vec16", 32'(dout16), 32'h4A);
    chk("s7_oe16", 32'(oe16), 32'h1);
    chk("s7_vec8_spur", 32'(dout8), 32'h47);
    inta_high();
    chk("s7_oe16_off", 32'(oe16), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
